mem_access_unit: RTL

- Initiator side of the data-memory interface: sits between the CPU load/store datapath and the byte-addressed, little-endian, word-port data memory.
- The memory offers only a combinational 32-bit read and a whole-word write at posedge.
- This block sequences word, halfword and byte loads and stores, doing read-modify-write for sub-word stores.
- It also performs alignment and range checks, and sign/zero extension of loads.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit.
// Carries two groups of signals:
//   CPU side:    req, we, size, unsigned_ld, addr, wdata -> ready, done, err, rdata
//   Memory side: mem_addr, mem_wdata, mem_we -> mem_rdata (combinational read)
// The slave modport is the access unit. The master modport is whatever drives
// the CPU side and models the word-port memory.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  unsigned_ld;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, size, unsigned_ld, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory interface.
// Sequences byte/halfword/word loads and stores against a little-endian,
// word-port memory that reads combinationally and writes a whole word at
// posedge. Sub-word stores use read-modify-write. The unit also checks
// alignment, range and size, and sign- or zero-extends sub-word loads.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    mem_access_unit_if.slave (CPU request/response + memory port)
// Flow: IDLE -> READ -> DONE (load), IDLE -> WRITE -> DONE (word store),
//       IDLE -> READ -> WRITE -> DONE (sub-word store), IDLE -> DONE (error).
module mem_access_unit #(
  parameter int MEM_BYTES  = 128,
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_BYTES - 4);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, buf_q, rdata_q;

  logic                  accept, req_err;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [31:0]           shifted, ld_ext, merged;

  assign accept   = (state == IDLE) && bus.req;
  assign req_word = {bus.addr[ADDR_WIDTH-1:2], 2'b00};

  // Misaligned, illegal size, or a word that does not fit inside memory.
  assign req_err = (bus.size == 2'b11)
                || (bus.size == SZ_HALF && bus.addr[0])
                || (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00)
                || (req_word > LAST_WORD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (req_err)                           state_nxt = DONE;
          else if (bus.we && bus.size == SZ_WORD) state_nxt = WRITE;
          else                                   state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= bus.we;
        uns_q   <= bus.unsigned_ld;
        err_q   <= req_err;
        size_q  <= bus.size;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state == READ) begin
        buf_q <= bus.mem_rdata;
        if (!we_q) rdata_q <= ld_ext;
      end
    end
  end

  // Halves are always 2-byte aligned on a legal access, so the byte-lane
  // shift also lands a halfword in the low 16 bits.
  assign shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = bus.mem_rdata;
    case (size_q)
      SZ_BYTE: ld_ext = uns_q ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_ext = uns_q ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // Replace only the addressed lane(s) of the word read in READ.
  always_comb begin
    merged = buf_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = (state == DONE) && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata = merged;
  // Decoded straight from state so an asynchronous reset kills the write
  // strobe immediately.
  assign bus.mem_we    = (state == WRITE);

endmodule
